// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_mux
// Purpose  : Drives DIGITS seven-segment digits from a packed BCD register.
//            Supports leading-zero blanking, whole-display blink and a dash
//            for invalid nibbles. It provides both a parallel registered
//            output and a time-multiplexed scan output.
// Ports    : clock    - system clock, rising edge
//            reset    - synchronous active-high reset
//            value    - packed BCD input, nibble i = digit i
//            load     - capture value into the display register
//            blank_lz - enable leading-zero blanking
//            blink_en - enable whole-display blinking
//            seg_all  - registered parallel segments, [7i+6:7i] = digit i
//            seg      - registered scan segments for the enabled digit
//            an       - registered active-low one-hot digit enable
// Segments : active-low, bit6 = g ... bit0 = a
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_mux #(
  parameter int                  DIGITS      = 4,
  parameter int                  SCAN_DIV    = 1000,
  parameter int                  BLINK_DIV   = 25000000,
  parameter logic [4*DIGITS-1:0] RESET_VALUE = 'h15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'h7F;
  localparam logic [6:0]    SEG_DASH   = 7'h3F;

  logic [4*DIGITS-1:0] disp_q,      disp_d;
  logic [7*DIGITS-1:0] seg_all_q,   seg_all_d;
  logic [6:0]          seg_q,       seg_d;
  logic [DIGITS-1:0]   an_q,        an_d;
  logic [SW-1:0]       scan_cnt_q,  scan_cnt_d;
  logic [IW-1:0]       idx_q,       idx_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q,     phase_d;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

  // Display register
  always_comb begin
    disp_d = load ? value : disp_q;
  end

  // Parallel decode. zero_run stays set while every more-significant nibble
  // seen so far is zero; invalid nibbles are nonzero and end the run.
  always_comb begin : decode_comb
    logic [3:0] nib;
    logic       zero_run;
    seg_all_d = '1;
    zero_run  = 1'b1;
    nib       = 4'h0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_q[4*i +: 4];
      if (phase_q) begin
        seg_all_d[7*i +: 7] = SEG_BLANK;
      end else if (blank_lz && zero_run && (nib == 4'h0) && (i != 0)) begin
        seg_all_d[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_all_d[7*i +: 7] = decode(nib);
      end
      zero_run = zero_run & (nib == 4'h0);
    end
  end

  // Scan path: an and seg come from the same index so they stay paired.
  always_comb begin
    seg_d = SEG_BLANK;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        seg_d = seg_all_q[7*d +: 7];
      end
    end
    an_d = ~(DIGITS'(1) << idx_q);

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
    end
  end

  // Blink timing; disabling blink clears the phase so the display is visible.
  always_comb begin
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      disp_q      <= RESET_VALUE;
      seg_all_q   <= '1;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      disp_q      <= disp_d;
      seg_all_q   <= seg_all_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign seg_all = seg_all_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule
`default_nettype wire

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
Parametrised successor to the two-digit countdown display driver. Drives DIGITS seven-segment digits from a packed BCD value, with these additional features:
- leading-zero blanking,
- whole-display blink,
- invalid-digit indication,
- time-multiplexed scan output alongside the parallel per-digit outputs.

It sits between the countdown/timer logic and the board display pins.

Parameters:
DIGITS, 4, number of BCD digits driven (legal 1..8); digit 0 is least significant
SCAN_DIV, 1000, clock cycles each digit is enabled on the scan output (legal >= 1)
BLINK_DIV, 25000000, clock cycles per blink half-period (legal >= 1)
RESET_VALUE, 'h15, 4*DIGITS-bit BCD value held in the display register after reset

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
value  input  4*DIGITS  packed BCD; nibble i = digit i
load  input  1  when high, value is captured into the display register
blank_lz  input  1  enables leading-zero blanking
blink_en  input  1  enables blinking of the whole display
seg_all  output  7*DIGITS  registered parallel segments; bits [7i+6:7i] = digit i
seg  output  7  registered scan segments for the currently enabled digit
an  output  DIGITS  registered active-low one-hot digit enable

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, named reset. Reset has priority over all other inputs.
- Segment code: active-low, bit6=g ... bit0=a.
  - Digits 0..9 map to 40,79,24,30,19,12,02,78,00,10 (hex).
  - Nibbles A..F are invalid and display a dash, 3F.
  - A blanked digit displays 7F.
- Reset values:
  - display register = RESET_VALUE
  - seg_all = all 7F; seg = 7F; an = all ones
  - scan counter = 0; digit index = 0
  - blink counter = 0; blink phase = 0
- Load: on an edge with load=1, the display register takes value. With load=0 it holds.
- Parallel path: seg_all is the registered decode of the display register. It has one cycle of latency after the display register updates, so seg_all reflects value two edges after the value/load sample edge.
  - The first valid seg_all appears on the first edge after reset deasserts, showing RESET_VALUE.
- Leading-zero blanking (blank_lz=1):
  - Scan from digit DIGITS-1 downward. Each digit whose nibble is 0 is blanked until the first nonzero nibble is reached.
  - Invalid nibbles count as nonzero.
  - Digit 0 is never blanked, so all-zero displays as blanks followed by "0".
  - blank_lz=0: no blanking.
- Blink:
  - While blink_en=1, the blink counter counts 0..BLINK_DIV-1. At terminal count it wraps to 0 and toggles the phase.
  - While phase=1, all digits decode as 7F; this overrides digit codes, dash and blanking.
  - When blink_en=0, counter and phase are forced to 0 on the next edge, and the display shows normally.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 continuously.
  - At terminal count it wraps, and the digit index advances index+1, wrapping DIGITS-1 -> 0.
  - Each cycle, an <= ~(1 << index) and seg <= seg_all slice[index], both registered from the same index and current seg_all. They are therefore always a consistent pair, lagging seg_all by one cycle.
  - SCAN_DIV=1 advances the index every cycle. DIGITS=1 holds an = 0 after reset.
- Simultaneous events:
  - load and a blink toggle on the same edge are independent; both take effect.
  - A load during scan does not restart the scan.
  - Reset mid-scan or mid-blink returns every register to its reset value on that edge.
- Width rules: counters are sized $clog2 of their divisor (minimum 1 bit). Index is $clog2(DIGITS) bits (minimum 1).

Test Plan:
1. Reset with defaults (DIGITS=4). Required: during reset seg_all = 7F7F7F7F, an = F, seg = 7F. First edge after release: seg_all = 40,40,79,12 (digits 3..0, "0015").
2. load value=16'h0915, blank_lz=0. Two edges later seg_all digits 3..0 = 40,10,79,12. Then blank_lz=1 gives 7F,10,79,12.
3. blank_lz=1: value 16'h0005 -> 7F,7F,7F,12. Value 16'h0000 -> 7F,7F,7F,40. Value 16'h0A00 -> 7F,3F,40,40.
4. BLINK_DIV=4, blink_en=1, value 16'h1234. Required: seg_all alternates between normal decode and 7F7F7F7F every 4 cycles. Dropping blink_en restores normal decode within 2 edges.
5. SCAN_DIV=3, DIGITS=4. Required:
   - an sequence E,D,B,7,E each held 3 cycles;
   - seg equals the matching seg_all slice every cycle;
   - reset asserted mid-sequence returns an = F, seg = 7F, and the scan restarts at digit 0.
